instr_fetch: RTL and testbench

Instruction fetch unit that sits directly upstream of the instruction BRAM (32-bit words, registered synchronous read, 1-cycle latency). It drives the BRAM byte address, pairs each returned word with its PC, and delivers instructions to decode through a valid/ready handshake. A 2-entry output buffer plus in-flight credit accounting absorbs decode back-pressure, because the BRAM output register updates on every clock. Branch redirects flush all buffered and in-flight words. The BRAM write enable is tied low at top level.

---
 rtl/instr_fetch.sv | 135 +++++++++++++
 tb/tb_instr_fetch.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch unit in front of a 1-cycle-latency instruction BRAM.
// Drives the BRAM byte address and tags each returned word with its PC.
// A 2-entry buffer with issue credits lets decode stall without losing the
// word the BRAM delivers on each clock.
//
// Ports:
//   sys_clk, sys_rst        clock, asynchronous active-high reset
//   mem_a        [15:0]     BRAM byte address (the pc register)
//   mem_di       [31:0]     BRAM read data for the address presented last cycle
//   fetch_en                allow new addresses to be issued
//   redirect, redirect_pc   one-cycle flush and restart at redirect_pc (word aligned)
//   ins_valid/ins_ready     valid/ready handshake to decode
//   ins_data     [31:0]     instruction word at the buffer head
//   ins_pc       [15:0]     byte address of ins_data
module instr_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  output logic [15:0] mem_a,
  input  logic [31:0] mem_di,
  input  logic        fetch_en,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] ins_data,
  output logic [15:0] ins_pc
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;

  logic [AW-1:0] pc;
  logic [AW-1:0] rsp_pc;
  logic          rsp_valid;

  // Two buffer slots; slot 0 is the head that drives the outputs.
  logic          v0, v1;
  logic [DW-1:0] d0, d1;
  logic [AW-1:0] p0, p1;
  logic          v0_n, v1_n;
  logic [DW-1:0] d0_n, d1_n;
  logic [AW-1:0] p0_n, p1_n;

  logic [1:0]    count;
  logic [2:0]    occ;
  logic          pop;
  logic          issue;

  // Low address bits of the redirect target are dropped by design.
  logic          unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign count = 2'(v0) + 2'(v1);
  assign pop   = v0 && ins_ready;
  assign occ   = 3'(count) + 3'(rsp_valid);
  // Issue only if the word it produces is guaranteed a buffer slot.
  assign issue = fetch_en && !redirect && ((occ - 3'(pop)) < 3'd2);

  // Address / in-flight tracking.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pc        <= RESET_PC;
      rsp_pc    <= '0;
      rsp_valid <= 1'b0;
    end else if (redirect) begin
      pc        <= {redirect_pc[AW-1:2], 2'b00};
      rsp_valid <= 1'b0;
    end else begin
      rsp_valid <= issue;
      if (issue) begin
        rsp_pc <= pc;
        pc     <= pc + AW'(4);
      end
    end
  end

  // Buffer next state: pop shifts slot 1 forward, push fills the first free slot.
  always_comb begin
    v0_n = v0;
    v1_n = v1;
    d0_n = d0;
    d1_n = d1;
    p0_n = p0;
    p1_n = p1;
    if (redirect) begin
      v0_n = 1'b0;
      v1_n = 1'b0;
    end else begin
      if (pop) begin
        v0_n = v1;
        d0_n = d1;
        p0_n = p1;
        v1_n = 1'b0;
      end
      if (rsp_valid) begin
        if (!v0_n) begin
          v0_n = 1'b1;
          d0_n = mem_di;
          p0_n = rsp_pc;
        end else begin
          v1_n = 1'b1;
          d1_n = mem_di;
          p1_n = rsp_pc;
        end
      end
    end
  end

  // Buffer registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      v0 <= 1'b0;
      v1 <= 1'b0;
      d0 <= '0;
      d1 <= '0;
      p0 <= '0;
      p1 <= '0;
    end else begin
      v0 <= v0_n;
      v1 <= v1_n;
      d0 <= d0_n;
      d1 <= d1_n;
      p0 <= p0_n;
      p1 <= p1_n;
    end
  end

  assign mem_a     = pc;
  assign ins_valid = v0;
  assign ins_data  = d0;
  assign ins_pc    = p0;

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: BRAM model (word n = A000_0000 + n) plus a
// reference stream model of expected PCs, with scenario tasks run in sequence.
module tb_instr_fetch;

  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [15:0] mem_a;
  logic [31:0] mem_di;
  logic        fetch_en;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins_data;
  logic [15:0] ins_pc;

  instr_fetch #(.RESET_PC(RESET_PC)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .mem_a      (mem_a),
    .mem_di     (mem_di),
    .fetch_en   (fetch_en),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .ins_data   (ins_data),
    .ins_pc     (ins_pc)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [31:0] word_of(input logic [15:0] a);
    return 32'hA000_0000 + 32'(a >> 2);
  endfunction

  // Registered-read BRAM.
  always @(posedge sys_clk) mem_di <= word_of(mem_a);

  int errors = 0;
  int checks = 0;
  int delivered = 0;

  logic [15:0] exp_pc;
  logic        hold_prev;
  logic [15:0] prev_pc;
  logic [31:0] prev_data;

  // A word landing while both slots stay occupied would be an overflow.
  always @(posedge sys_clk) begin
    if (!sys_rst) begin
      checks++;
      if (dut.rsp_valid && dut.count == 2'd2 && !(ins_valid && ins_ready) && !redirect) begin
        errors++;
        $display("FAIL overflow: push with count=%0d and no pop at time %0t", dut.count, $time);
      end
    end
  end

  // One clock: scoreboard any transfer, check hold stability, then advance.
  task automatic cycle();
    if (hold_prev) begin
      checks++;
      if (ins_valid !== 1'b1 || ins_pc !== prev_pc || ins_data !== prev_data) begin
        errors++;
        $display("FAIL hold_stable: valid=%b pc=%h data=%h required valid=1 pc=%h data=%h",
                 ins_valid, ins_pc, ins_data, prev_pc, prev_data);
      end
    end
    if (ins_valid && ins_ready) begin
      checks++;
      if (ins_pc !== exp_pc || ins_data !== word_of(exp_pc)) begin
        errors++;
        $display("FAIL stream: pc=%h data=%h required pc=%h data=%h",
                 ins_pc, ins_data, exp_pc, word_of(exp_pc));
      end
      exp_pc = exp_pc + 16'd4;
      delivered++;
    end
    hold_prev = ins_valid && !ins_ready && !redirect;
    prev_pc   = ins_pc;
    prev_data = ins_data;
    if (redirect) exp_pc = {redirect_pc[15:2], 2'b00};
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    sys_rst     = 1'b1;
    fetch_en    = 1'b0;
    ins_ready   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    hold_prev   = 1'b0;
    exp_pc      = RESET_PC;
    repeat (2) @(posedge sys_clk);
    #1;
    checks++;
    if (ins_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", ins_valid); end
    checks++;
    if (ins_data !== 32'h0) begin errors++; $display("FAIL rst_data: got %h required 0", ins_data); end
    checks++;
    if (ins_pc !== 16'h0) begin errors++; $display("FAIL rst_pc: got %h required 0", ins_pc); end
    checks++;
    if (mem_a !== RESET_PC) begin errors++; $display("FAIL rst_mem_a: got %h required %h", mem_a, RESET_PC); end
    sys_rst   = 1'b0;
    fetch_en  = 1'b1;
    ins_ready = 1'b1;
    @(posedge sys_clk); #1;  // E1
    checks++;
    if (ins_valid !== 1'b0 || mem_a !== RESET_PC + 16'd4) begin
      errors++;
      $display("FAIL e1: valid=%b mem_a=%h required valid=0 mem_a=%h", ins_valid, mem_a, RESET_PC + 16'd4);
    end
    @(posedge sys_clk); #1;  // E2
    checks++;
    if (ins_valid !== 1'b1 || ins_pc !== RESET_PC || ins_data !== 32'hA000_0000) begin
      errors++;
      $display("FAIL e2_first: valid=%b pc=%h data=%h required 1 %h a0000000", ins_valid, ins_pc, ins_data, RESET_PC);
    end
    repeat (12) begin
      checks++;
      if (ins_valid !== 1'b1) begin errors++; $display("FAIL no_bubble: valid=%b required 1", ins_valid); end
      cycle();
    end
  endtask

  task automatic test_stall();
    logic [15:0] frozen;
    int n0;
    ins_ready = 1'b0;
    cycle();
    frozen = mem_a;
    repeat (4) begin
      cycle();
      checks++;
      if (mem_a !== frozen) begin errors++; $display("FAIL stall_mem_a: got %h required %h", mem_a, frozen); end
    end
    checks++;
    if (dut.count !== 2'd2) begin errors++; $display("FAIL stall_count: got %0d required 2", dut.count); end
    ins_ready = 1'b1;
    n0 = delivered;
    repeat (10) cycle();
    checks++;
    if (delivered - n0 < 9) begin errors++; $display("FAIL stall_release_rate: got %0d required >=9", delivered - n0); end
  endtask

  task automatic test_redirect();
    ins_ready = 1'b0;
    repeat (3) cycle();
    redirect    = 1'b1;
    redirect_pc = 16'h0103;
    cycle();  // edge R
    redirect = 1'b0;
    checks++;
    if (ins_valid !== 1'b0 || mem_a !== 16'h0100) begin
      errors++;
      $display("FAIL redir_r: valid=%b mem_a=%h required 0 0100", ins_valid, mem_a);
    end
    cycle();  // R+1
    checks++;
    if (ins_valid !== 1'b0) begin errors++; $display("FAIL redir_r1: valid=%b required 0", ins_valid); end
    cycle();  // R+2
    checks++;
    if (ins_valid !== 1'b1 || ins_pc !== 16'h0100 || ins_data !== 32'hA000_0040) begin
      errors++;
      $display("FAIL redir_r2: valid=%b pc=%h data=%h required 1 0100 a0000040", ins_valid, ins_pc, ins_data);
    end
    ins_ready = 1'b1;
    repeat (6) cycle();
  endtask

  task automatic test_wrap();
    logic [15:0] want [4];
    want = '{16'hFFF8, 16'hFFFC, 16'h0000, 16'h0004};
    ins_ready   = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 16'hFFF8;
    cycle();
    redirect = 1'b0;
    for (int i = 0; i < 4; i++) begin
      int guard = 0;
      while (!ins_valid && guard < 10) begin
        cycle();
        guard++;
      end
      checks++;
      if (ins_valid !== 1'b1 || ins_pc !== want[i] || ins_data !== word_of(want[i])) begin
        errors++;
        $display("FAIL wrap_%0d: valid=%b pc=%h data=%h required 1 %h %h",
                 i, ins_valid, ins_pc, ins_data, want[i], word_of(want[i]));
      end
      cycle();
    end
  endtask

  task automatic test_random();
    logic [15:0] frozen;
    int n0;
    n0 = delivered;
    frozen = '0;
    for (int c = 0; c < 2000; c++) begin
      if (c == 100) frozen = mem_a;
      if (c > 100 && c <= 104) begin
        checks++;
        if (mem_a !== frozen) begin errors++; $display("FAIL fetch_en_hold: mem_a=%h required %h", mem_a, frozen); end
      end
      fetch_en  = !(c >= 100 && c < 104);
      ins_ready = 1'($urandom_range(0, 1));
      redirect  = 1'b0;
      if (c > 200 && $urandom_range(0, 99) == 0) begin
        redirect    = 1'b1;
        redirect_pc = 16'($urandom);
      end
      cycle();
    end
    redirect  = 1'b0;
    fetch_en  = 1'b1;
    ins_ready = 1'b1;
    repeat (5) cycle();
    checks++;
    if (delivered - n0 < 400) begin errors++; $display("FAIL random_progress: delivered %0d required >=400", delivered - n0); end
  endtask

  task automatic test_async_reset();
    ins_ready = 1'b0;
    fetch_en  = 1'b1;
    repeat (3) cycle();
    checks++;
    if (dut.count !== 2'd2 || ins_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_full: count=%0d valid=%b required 2 1", dut.count, ins_valid);
    end
    #3 sys_rst = 1'b1;
    #1;
    checks++;
    if (ins_valid !== 1'b0 || ins_data !== 32'h0 || ins_pc !== 16'h0 || mem_a !== RESET_PC) begin
      errors++;
      $display("FAIL async_reset: valid=%b data=%h pc=%h mem_a=%h required 0 0 0 %h",
               ins_valid, ins_data, ins_pc, mem_a, RESET_PC);
    end
    hold_prev = 1'b0;
    exp_pc    = RESET_PC;
    @(posedge sys_clk); #1;
    sys_rst   = 1'b0;
    ins_ready = 1'b1;
    @(posedge sys_clk); #1;  // E1
    checks++;
    if (ins_valid !== 1'b0) begin errors++; $display("FAIL restart_e1: valid=%b required 0", ins_valid); end
    @(posedge sys_clk); #1;  // E2
    checks++;
    if (ins_valid !== 1'b1 || ins_pc !== RESET_PC || ins_data !== 32'hA000_0000) begin
      errors++;
      $display("FAIL restart_e2: valid=%b pc=%h data=%h required 1 %h a0000000", ins_valid, ins_pc, ins_data, RESET_PC);
    end
    repeat (4) cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_stall();
    test_redirect();
    test_wrap();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
